// File: rtl/bexkat_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter for the Bexkat core buses.
// The grant FSM is registered, the signal muxing is combinational, and a per-transfer ack watchdog is included.
module bexkat_bus_arbiter #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o,
    output logic          timeout_o
);

    localparam int              WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [WDW-1:0]  WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WDW-1:0]  WD_MAX  = {WDW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT0,
        S_GNT1,
        S_ERR0,
        S_ERR1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;     // 0: m0 was granted last, 1: m1
    logic [WDW-1:0]  r_wdog;
    logic            w_wd_inc;
    logic            w_expire;

    // Next-state and watchdog decisions
    always_comb begin
        w_next   = r_state;
        w_wd_inc = 1'b0;
        w_expire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_next = r_last ? S_GNT0 : S_GNT1;
                else if (m0_cyc_i)
                    w_next = S_GNT0;
                else if (m1_cyc_i)
                    w_next = S_GNT1;
            end
            S_GNT0: begin
                if (!m0_cyc_i) begin
                    w_next = m1_cyc_i ? S_GNT1 : S_IDLE;
                end else if (m0_stb_i && !s_ack_i) begin
                    w_wd_inc = 1'b1;
                    if (WD_EN && r_wdog == WD_LAST) begin
                        w_expire = 1'b1;
                        w_next   = S_ERR0;
                    end
                end
            end
            S_GNT1: begin
                if (!m1_cyc_i) begin
                    w_next = m0_cyc_i ? S_GNT0 : S_IDLE;
                end else if (m1_stb_i && !s_ack_i) begin
                    w_wd_inc = 1'b1;
                    if (WD_EN && r_wdog == WD_LAST) begin
                        w_expire = 1'b1;
                        w_next   = S_ERR1;
                    end
                end
            end
            S_ERR0: begin
                if (!m0_cyc_i)
                    w_next = m1_cyc_i ? S_GNT1 : S_IDLE;
            end
            S_ERR1: begin
                if (!m1_cyc_i)
                    w_next = m0_cyc_i ? S_GNT0 : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_GNT0 && r_state != S_GNT0)
                r_last <= 1'b0;
            else if (w_next == S_GNT1 && r_state != S_GNT1)
                r_last <= 1'b1;
            // Saturate rather than wrap when the watchdog is disabled
            if (w_next != r_state || !w_wd_inc)
                r_wdog <= '0;
            else if (r_wdog != WD_MAX)
                r_wdog <= r_wdog + 1'b1;
        end
    end

    // Slave-side muxing and master responses
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        gnt_o    = 2'b00;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            S_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                gnt_o    = 2'b01;
                m0_ack_o = s_ack_i;
            end
            S_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                gnt_o    = 2'b10;
                m1_ack_o = s_ack_i;
            end
            S_ERR0: begin
                gnt_o    = 2'b01;
                m0_err_o = 1'b1;
            end
            S_ERR1: begin
                gnt_o    = 2'b10;
                m1_err_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign timeout_o = w_expire;

endmodule

// File: tb/tb_bexkat_bus_arbiter.sv
// Directed bench for bexkat_bus_arbiter.
// A behavioural ownership model is checked against the DUT on every falling edge, alongside hand-computed spot checks.
module tb_bexkat_bus_arbiter;

    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk_i, rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]    m0_sel_i, m1_sel_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o, s_dat_i;
    logic [1:0]    gnt_o;

    int checks   = 0;
    int failures = 0;

    bexkat_bus_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 none), whether that owner is in error,
    // who was granted last, and how many consecutive unacked strobe cycles have passed.
    int md_own   = -1;
    bit md_err   = 0;
    int md_last  = 1;
    int md_stall = 0;

    function automatic logic cyc_of(input int m);
        return (m == 1) ? m1_cyc_i : m0_cyc_i;
    endfunction
    function automatic logic stb_of(input int m);
        return (m == 1) ? m1_stb_i : m0_stb_i;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            md_own = -1; md_err = 0; md_last = 1; md_stall = 0;
        end else if (md_own < 0) begin
            if (m0_cyc_i && m1_cyc_i) md_own = (md_last == 1) ? 0 : 1;
            else if (m0_cyc_i)        md_own = 0;
            else if (m1_cyc_i)        md_own = 1;
            if (md_own >= 0) md_last = md_own;
            md_stall = 0;
        end else if (!cyc_of(md_own)) begin
            md_err   = 0;
            md_stall = 0;
            md_own   = cyc_of(1 - md_own) ? 1 - md_own : -1;
            if (md_own >= 0) md_last = md_own;
        end else if (!md_err) begin
            if (stb_of(md_own) && !s_ack_i) begin
                if (TO != 0 && md_stall == TO - 1) begin
                    md_err = 1; md_stall = 0;
                end else begin
                    md_stall++;
                end
            end else begin
                md_stall = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        logic          act, e_cyc, e_stb, e_we, e_to;
        logic [3:0]    e_sel;
        logic [AW-1:0] e_adr;
        logic [31:0]   e_dat;
        logic [1:0]    e_gnt;
        act   = (md_own >= 0) && !md_err;
        e_gnt = (md_own < 0) ? 2'b00 : ((md_own == 0) ? 2'b01 : 2'b10);
        e_cyc = act && cyc_of(md_own);
        e_stb = act && stb_of(md_own);
        e_we  = act && ((md_own == 1) ? m1_we_i : m0_we_i);
        e_sel = act ? ((md_own == 1) ? m1_sel_i : m0_sel_i) : 4'h0;
        e_adr = act ? ((md_own == 1) ? m1_adr_i : m0_adr_i) : '0;
        e_dat = act ? ((md_own == 1) ? m1_dat_i : m0_dat_i) : 32'h0;
        e_to  = e_cyc && e_stb && !s_ack_i && (md_stall == TO - 1);
        chk("model_ctl",
            {18'h0, s_cyc_o, s_stb_o, s_we_o, s_sel_o, gnt_o,
             m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o},
            {18'h0, e_cyc, e_stb, e_we, e_sel, e_gnt,
             act && md_own == 0 && s_ack_i, md_own == 0 && md_err,
             act && md_own == 1 && s_ack_i, md_own == 1 && md_err, e_to});
        chk("model_adr", s_adr_o, e_adr);
        chk("model_wdat", s_dat_o, e_dat);
        chk("model_rdat", {m0_dat_o ^ s_dat_i} | {m1_dat_o ^ s_dat_i}, 32'h0);
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    int n_stb, n_to;

    initial begin
        rst_i = 1'b1;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_adr_i = '0; m0_dat_i = 32'h0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_adr_i = '0; m1_dat_i = 32'h0;
        s_ack_i = 0; s_dat_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("reset_gnt", {30'h0, gnt_o}, 32'h0);
        chk("reset_scyc", {31'h0, s_cyc_o}, 32'h0);
        rst_i = 1'b0;

        // Tie straight out of reset: m0 first, then m1 with no idle bubble
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_0100; m0_sel_i = 4'hF;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0200; m1_sel_i = 4'hF;
        step();
        chk("tie_gnt", {30'h0, gnt_o}, 32'h1);
        s_ack_i = 1; s_dat_i = 32'h1111_1111;
        #1 chk("tie_m0_ack", {31'h0, m0_ack_o}, 32'h1);
        chk("tie_m1_noack", {31'h0, m1_ack_o}, 32'h0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1 chk("tie_hold", {30'h0, gnt_o}, 32'h1);
        step();
        chk("tie_handover", {30'h0, gnt_o}, 32'h2);
        s_ack_i = 1;
        step();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step();
        chk("tie_idle", {30'h0, gnt_o}, 32'h0);
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        chk("tie2_gnt", {30'h0, gnt_o}, 32'h1);
        s_ack_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step();

        // Burst: m1 wins the tie this time and keeps the bus for 4 beats
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_4000;
        step();
        chk("burst_gnt", {30'h0, gnt_o}, 32'h2);
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = 32'hA000_0000 + i; m1_adr_i = 32'h0000_4000 + 4 * i;
            #1 chk("burst_hold", {30'h0, gnt_o}, 32'h2);
            chk("burst_m1_ack", {31'h0, m1_ack_o}, 32'h1);
            chk("burst_m0_noack", {31'h0, m0_ack_o}, 32'h0);
            step();
        end
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step();
        chk("burst_m0_next", {30'h0, gnt_o}, 32'h1);
        s_ack_i = 1;
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        step();

        // Single master read with slave ack two cycles after strobe
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF;
        step();
        chk("single_gnt", {30'h0, gnt_o}, 32'h1);
        chk("single_adr", s_adr_o, 32'h0000_1000);
        step();
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1 chk("single_ack", {31'h0, m0_ack_o}, 32'h1);
        chk("single_rdat", m0_dat_o, 32'hDEAD_BEEF);
        chk("single_m1_noack", {31'h0, m1_ack_o}, 32'h0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        step();
        chk("single_idle", {30'h0, gnt_o}, 32'h0);

        // Watchdog expiry on an unacked write
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h0000_2000; m0_dat_i = 32'h1234_5678;
        n_stb = 0; n_to = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            #1 n_stb += int'(s_stb_o); n_to += int'(timeout_o);
            if (i == 7) chk("wd_pulse_cycle", {31'h0, timeout_o}, 32'h1);
        end
        chk("wd_err", {31'h0, m0_err_o}, 32'h1);
        chk("wd_cyc_low", {31'h0, s_cyc_o}, 32'h0);
        chk("wd_stb_cycles", n_stb, 8);
        chk("wd_pulses", n_to, 1);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        step();
        step();
        chk("wd_idle", {30'h0, gnt_o}, 32'h0);
        chk("wd_err_clear", {31'h0, m0_err_o}, 32'h0);

        // Ack on the would-be expiry cycle wins
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        n_to = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) begin s_ack_i = 1; s_dat_i = 32'h0BAD_F00D; end
            #1 n_to += int'(timeout_o);
            if (i == 7) chk("late_ack", {31'h0, m0_ack_o}, 32'h1);
        end
        step();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; s_ack_i = 0;
        #1 chk("late_no_err", {31'h0, m0_err_o}, 32'h0);
        chk("late_no_timeout", n_to, 0);
        step();
        step();

        // Asynchronous reset in the middle of a GNT1 transfer
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_8000;
        step();
        chk("rst_pre_gnt", {30'h0, gnt_o}, 32'h2);
        #1 rst_i = 1;
        #1 chk("rst_async", {29'h0, s_cyc_o, gnt_o}, 32'h0);
        step();
        rst_i = 0;
        step();
        chk("rst_regrant", {30'h0, gnt_o}, 32'h2);
        m1_cyc_i = 0; m1_stb_i = 0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bexkat_bus_arbiter.md
Name: bexkat_bus_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the CPU core's data bus (master 0) and instruction bus (master 1) share a single memory/peripheral port.
- Registered grant FSM with round-robin tie-break, combinational signal muxing and a per-transfer ack watchdog.
- The watchdog returns a bus error to the stalled master so the core can raise a bus-fault exception instead of hanging.

Parameters:
- AW, 32, address width of all adr ports.
- TIMEOUT, 255, cycles to wait for s_ack_i before erroring; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (data) cycle/strobe/write
- m0_sel_i  in  4  master 0 byte enables
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  master 0 ack/error
- m1_*  same set as m0_*  master 1 (instruction)
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle/strobe/write
- s_sel_o  out  4  slave byte enables
- s_adr_o  out  AW  slave address
- s_dat_o  out  32  slave write data
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- gnt_o  out  2  one-hot current grant, {m1,m0}
- timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset is asynchronous, active-high on rst_i; clock is clk_i.
- On reset:
  - state=IDLE, last=1 so m0 wins the first tie, watchdog counter=0.
  - All s_* control outputs 0, gnt_o=0, acks/errs 0, timeout_o 0.
- States: IDLE, GNT0, GNT1, ERR0, ERR1.
- IDLE:
  - No slave cycle; s_cyc_o=s_stb_o=s_we_o=0, s_sel_o=0, s_adr_o=0, s_dat_o=0.
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master that is not `last`.
- Arbitration latency: a request seen in IDLE gets its grant on the next clock edge. Masters hold cyc/stb until ack per Wishbone classic.
- GNTx:
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o are combinationally driven from master x.
  - mx_ack_o = s_ack_i. The other master's ack/err are forced 0.
  - last<=x on entry.
  - Grant is held while mx_cyc_i=1, including multi-beat bursts; no preemption.
  - mx_cyc_i low with the other master's cyc high -> go straight to that master's GNT state (no IDLE bubble).
  - mx_cyc_i low with the other master idle -> IDLE.
- m0_dat_o and m1_dat_o both carry s_dat_i at all times. Only the granted master sees ack.
- Watchdog:
  - Counter increments each cycle in GNTx with mx_stb_i=1 and s_ack_i=0.
  - Cleared on s_ack_i, on mx_stb_i=0, and on any state change.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack that cycle -> next state ERRx, timeout_o=1 for that one cycle.
  - Width is clog2(TIMEOUT+1); the counter never wraps.
- ERRx:
  - s_cyc_o=s_stb_o=0; mx_err_o=1 continuously, mx_ack_o=0.
  - Stays until mx_cyc_i=0, then follows the GNTx exit rules: other master requesting -> its GNT, else IDLE.
- An s_ack_i arriving in the same cycle as expiry counts as an ack and no error is raised.
- gnt_o is one-hot for GNT0/ERR0 (01) and GNT1/ERR1 (10), 00 in IDLE.
- An s_ack_i while in IDLE or ERRx is ignored.
- Reset mid-transfer: immediate return to the reset state. The slave sees cyc drop asynchronously.

Test Plan:
- Single master: m0 reads 0x00001000, slave acks 2 cycles after s_stb_o -> gnt_o=01 one cycle after m0_cyc_i; m0_ack_o pulses with s_dat_i=0xDEADBEEF on m0_dat_o; m1_ack_o stays 0.
- Tie from reset: m0 and m1 assert cyc in the same cycle -> m0 granted first. When m0 drops cyc, gnt_o goes 01->10 on the next edge with no IDLE cycle. Repeat the tie from IDLE -> m0 is granted again, since last=1.
- Burst hold: m1 issues 4 consecutive acked beats while m0 requests -> gnt_o stays 10 for all 4 acks; m0 is granted the cycle after m1_cyc_i drops.
- Watchdog, TIMEOUT=8: m0 write with no s_ack_i -> 8 cycles of s_stb_o, then timeout_o pulses once, m0_err_o=1 and s_cyc_o=0 until m0_cyc_i drops, then IDLE.
- Ack on the expiry cycle with TIMEOUT=8: s_ack_i arrives on the 8th stb cycle -> m0_ack_o=1, no timeout_o, no m0_err_o.
- Async reset asserted mid-GNT1 -> all outputs 0 without waiting for a clock edge. After release with m1 still requesting, gnt_o=10 one cycle later.
